trdb_packet_emitter: RTL and testbench

TRDB_PACKET_EMITTER -- requirements
Module: trdb_packet_emitter

---
 rtl/trdb_pkg.sv | 35 +++
 rtl/trdb_packet_fifo.sv | 56 +++++
 rtl/trdb_packet_emitter.sv | 133 +++++++++++++
 tb/tb_trdb_packet_emitter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/trdb_pkg.sv
// Shared types and sizes for the trace debug packet emitter.
// Bench builds use PTYPE_LEN=2, P_LEN=5, PAYLOAD_LEN=64.
package trdb_pkg;

  localparam int PTYPE_LEN   = 2;
  localparam int P_LEN       = 5;
  localparam int PAYLOAD_LEN = 64;
  localparam int MAX_BYTES   = PAYLOAD_LEN / 8;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PAYLOAD
  } emit_state_e;

  typedef struct packed {
    logic [PTYPE_LEN-1:0]   ptype;
    logic [P_LEN-1:0]       length;
    logic [PAYLOAD_LEN-1:0] payload;
  } packet_t;

  function automatic logic [7:0] hdr_byte(
    input packet_t p
  );
    return 8'({p.ptype, p.length});
  endfunction

  function automatic logic [7:0] pl_byte(
    input packet_t p,
    input int      idx
  );
    return p.payload[8*idx +: 8];
  endfunction

endpackage

// File: rtl/trdb_packet_fifo.sv
// Synchronous FIFO holding whole packets between encoder
// and serializer; pushes into a full FIFO are ignored.
module trdb_packet_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
    $error("FIFO depth must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign full_o  = count == (AW+1)'(DEPTH);
  assign empty_o = count == '0;
  assign data_o  = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/trdb_packet_emitter.sv
// Queues trace packets and serializes each as one header
// byte followed by its payload bytes on a valid/ready port.
module trdb_packet_emitter
  import trdb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int LOST_CNT_W = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   packet_valid_i,
  input  logic [PTYPE_LEN-1:0]   packet_type_i,
  input  logic [P_LEN-1:0]       packet_length_i,
  input  logic [PAYLOAD_LEN-1:0] packet_payload_i,
  output logic                   byte_valid_o,
  input  logic                   byte_ready_i,
  output logic [7:0]             byte_data_o,
  output logic                   byte_last_o,
  output logic                   drop_o,
  output logic [LOST_CNT_W-1:0]  lost_cnt_o
);

  localparam int IDX_W =
    (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

  if (PTYPE_LEN + P_LEN > 8) begin : g_bad_hdr
    $error("type and length do not fit one byte");
  end

  emit_state_e      state;
  packet_t          in_pkt;
  packet_t          fifo_pkt;
  packet_t          pkt;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic             last_nxt;
  logic             malformed;
  logic             push;
  logic             pop;
  logic             xfer;
  logic             fifo_full;
  logic             fifo_empty;

  assign in_pkt = '{
    ptype:   packet_type_i,
    length:  packet_length_i,
    payload: packet_payload_i
  };

  assign malformed = (packet_length_i == '0) ||
                     (int'(packet_length_i) > MAX_BYTES);
  assign push     = packet_valid_i && !malformed;
  assign xfer     = byte_valid_o && byte_ready_i;
  assign idx_nxt  = idx + 1'b1;
  assign last_nxt = P_LEN'(idx_nxt) ==
                    (pkt.length - P_LEN'(1));

  // Pop on idle, or back-to-back on the last byte
  assign pop = !fifo_empty &&
               ((state == IDLE) ||
                (state == PAYLOAD && xfer && byte_last_o));

  trdb_packet_fifo #(
    .WIDTH ($bits(packet_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (in_pkt),
    .pop_i   (pop),
    .data_o  (fifo_pkt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      idx          <= '0;
      pkt          <= '0;
      byte_valid_o <= 1'b0;
      byte_data_o  <= '0;
      byte_last_o  <= 1'b0;
      drop_o       <= 1'b0;
      lost_cnt_o   <= '0;
    end else begin
      drop_o <= packet_valid_i && malformed;
      if (push && fifo_full && lost_cnt_o != '1)
        lost_cnt_o <= lost_cnt_o + 1'b1;
      unique case (state)
        IDLE: begin
          if (!fifo_empty) begin
            pkt          <= fifo_pkt;
            state        <= HEADER;
            byte_valid_o <= 1'b1;
            byte_data_o  <= hdr_byte(fifo_pkt);
            byte_last_o  <= 1'b0;
          end
        end
        HEADER: begin
          if (xfer) begin
            state       <= PAYLOAD;
            idx         <= '0;
            byte_data_o <= pl_byte(pkt, 0);
            byte_last_o <= pkt.length == P_LEN'(1);
          end
        end
        PAYLOAD: begin
          if (xfer && byte_last_o) begin
            if (!fifo_empty) begin
              pkt         <= fifo_pkt;
              state       <= HEADER;
              byte_data_o <= hdr_byte(fifo_pkt);
              byte_last_o <= 1'b0;
            end else begin
              state        <= IDLE;
              byte_valid_o <= 1'b0;
              byte_data_o  <= '0;
              byte_last_o  <= 1'b0;
            end
          end else if (xfer) begin
            idx         <= idx_nxt;
            byte_data_o <= pl_byte(pkt, int'(idx_nxt));
            byte_last_o <= last_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trdb_packet_emitter.sv
// Directed bench: cycle table for basic streams and drops,
// plus sequences for backpressure, overflow and reset.
module tb_trdb_packet_emitter;
  import trdb_pkg::*;

  localparam int DEPTH = 4;
  localparam int LW    = 8;

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic                   packet_valid_i;
  logic [PTYPE_LEN-1:0]   packet_type_i;
  logic [P_LEN-1:0]       packet_length_i;
  logic [PAYLOAD_LEN-1:0] packet_payload_i;
  logic                   byte_valid_o;
  logic                   byte_ready_i;
  logic [7:0]             byte_data_o;
  logic                   byte_last_o;
  logic                   drop_o;
  logic [LW-1:0]          lost_cnt_o;

  trdb_packet_emitter #(
    .FIFO_DEPTH (DEPTH),
    .LOST_CNT_W (LW)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .packet_valid_i   (packet_valid_i),
    .packet_type_i    (packet_type_i),
    .packet_length_i  (packet_length_i),
    .packet_payload_i (packet_payload_i),
    .byte_valid_o     (byte_valid_o),
    .byte_ready_i     (byte_ready_i),
    .byte_data_o      (byte_data_o),
    .byte_last_o      (byte_last_o),
    .drop_o           (drop_o),
    .lost_cnt_o       (lost_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic                   v;
    logic [PTYPE_LEN-1:0]   t;
    logic [P_LEN-1:0]       l;
    logic [PAYLOAD_LEN-1:0] p;
    logic                   ev;
    logic [7:0]             ed;
    logic                   el;
    logic                   edr;
  } vec_t;

  vec_t       tbl [17];
  logic [8:0] rx_q [$];
  logic [8:0] ex_q [$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] hold_d;
  logic       hold_l;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Log the transfer happening at the coming edge,
  // then move to the next falling edge.
  task automatic tick();
    if (byte_valid_o === 1'b1 && byte_ready_i && !rst_i)
      rx_q.push_back({byte_last_o, byte_data_o});
    @(negedge clk_i);
  endtask

  task automatic idle_in();
    packet_valid_i   = 1'b0;
    packet_type_i    = '0;
    packet_length_i  = '0;
    packet_payload_i = '0;
  endtask

  task automatic send(input logic [PTYPE_LEN-1:0] t,
                      input logic [P_LEN-1:0] l,
                      input logic [PAYLOAD_LEN-1:0] p);
    packet_valid_i   = 1'b1;
    packet_type_i    = t;
    packet_length_i  = l;
    packet_payload_i = p;
  endtask

  task automatic model(input logic [PTYPE_LEN-1:0] t,
                       input logic [P_LEN-1:0] l,
                       input logic [PAYLOAD_LEN-1:0] p);
    ex_q.push_back({1'b0, 8'({t, l})});
    for (int i = 0; i < int'(l); i++)
      ex_q.push_back({i == int'(l) - 1, p[8*i +: 8]});
  endtask

  task automatic check_stream(input string name,
                              input int budget);
    int b = 0;
    while (rx_q.size() < ex_q.size() && b < budget) begin
      tick();
      b++;
    end
    repeat (3) tick();
    check({name, " count"}, rx_q.size(), ex_q.size());
    for (int i = 0; i < ex_q.size(); i++)
      if (i < rx_q.size())
        check($sformatf("%s byte%0d", name, i),
              rx_q[i], ex_q[i]);
    rx_q.delete();
    ex_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    rst_i        = 1'b1;
    byte_ready_i = 1'b1;
    idle_in();
    tick();
    tick();
    check("rst valid", byte_valid_o, 0);
    check("rst last", byte_last_o, 0);
    check("rst data", byte_data_o, 0);
    check("rst drop", drop_o, 0);
    check("rst lost", lost_cnt_o, 0);
    rst_i = 1'b0;
    tick();

    tbl[0]  = '{1, 2, 3, 64'hCCBBAA, 0, 8'h00, 0, 0};
    tbl[1]  = '{0, 0, 0, 64'h0, 1, 8'h43, 0, 0};
    tbl[2]  = '{0, 0, 0, 64'h0, 1, 8'hAA, 0, 0};
    tbl[3]  = '{0, 0, 0, 64'h0, 1, 8'hBB, 0, 0};
    tbl[4]  = '{0, 0, 0, 64'h0, 1, 8'hCC, 1, 0};
    tbl[5]  = '{0, 0, 0, 64'h0, 0, 8'h00, 0, 0};
    tbl[6]  = '{1, 1, 1, 64'h11, 0, 8'h00, 0, 0};
    tbl[7]  = '{1, 3, 2, 64'h3322, 1, 8'h21, 0, 0};
    tbl[8]  = '{0, 0, 0, 64'h0, 1, 8'h11, 1, 0};
    tbl[9]  = '{0, 0, 0, 64'h0, 1, 8'h62, 0, 0};
    tbl[10] = '{0, 0, 0, 64'h0, 1, 8'h22, 0, 0};
    tbl[11] = '{0, 0, 0, 64'h0, 1, 8'h33, 1, 0};
    tbl[12] = '{0, 0, 0, 64'h0, 0, 8'h00, 0, 0};
    tbl[13] = '{1, 2, 0, 64'hFF, 0, 8'h00, 0, 1};
    tbl[14] = '{0, 0, 0, 64'h0, 0, 8'h00, 0, 0};
    tbl[15] = '{1, 2, 9, 64'hFF, 0, 8'h00, 0, 1};
    tbl[16] = '{0, 0, 0, 64'h0, 0, 8'h00, 0, 0};

    for (int i = 0; i < 17; i++) begin
      packet_valid_i   = tbl[i].v;
      packet_type_i    = tbl[i].t;
      packet_length_i  = tbl[i].l;
      packet_payload_i = tbl[i].p;
      tick();
      check($sformatf("row%0d valid", i),
            byte_valid_o, tbl[i].ev);
      check($sformatf("row%0d data", i),
            byte_data_o, tbl[i].ed);
      check($sformatf("row%0d last", i),
            byte_last_o, tbl[i].el);
      check($sformatf("row%0d drop", i),
            drop_o, tbl[i].edr);
      check($sformatf("row%0d lost", i), lost_cnt_o, 0);
    end
    idle_in();
    rx_q.delete();

    // backpressure in the middle of a max-length payload
    send(0, 8, 64'h8877665544332211);
    model(0, 8, 64'h8877665544332211);
    tick();
    idle_in();
    b = 0;
    while (rx_q.size() < 3 && b < 20) begin
      tick();
      b++;
    end
    byte_ready_i = 1'b0;
    hold_d = byte_data_o;
    hold_l = byte_last_o;
    check("bp byte", hold_d, 8'h33);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("bp valid%0d", k), byte_valid_o, 1);
      check($sformatf("bp data%0d", k), byte_data_o, hold_d);
      check($sformatf("bp last%0d", k), byte_last_o, hold_l);
    end
    byte_ready_i = 1'b1;
    check_stream("bp", 40);

    // holding register plus FIFO absorb DEPTH+1 packets
    byte_ready_i = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      send(1, 1, 64'(8'h10 + i));
      if (i <= DEPTH) model(1, 1, 64'(8'h10 + i));
      tick();
    end
    idle_in();
    tick();
    check("ovf lost1", lost_cnt_o, 1);
    byte_ready_i = 1'b1;
    tick();
    check("ovf last", byte_last_o, 1);
    send(2, 1, 64'hEE);
    tick();
    idle_in();
    check("ovf lost2", lost_cnt_o, 2);
    check_stream("ovf", 100);

    byte_ready_i = 1'b0;
    for (int i = 0; i < DEPTH + 1 + 300; i++) begin
      send(1, 1, 64'h5A);
      tick();
      if (i == DEPTH + 252)
        check("sat 254", lost_cnt_o, 254);
    end
    idle_in();
    tick();
    check("sat 255", lost_cnt_o, 255);

    // reset mid-packet with two packets queued
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("rst2 valid", byte_valid_o, 0);
    check("rst2 lost", lost_cnt_o, 0);
    rx_q.delete();
    send(2, 3, 64'h030201);
    tick();
    send(1, 1, 64'h55);
    tick();
    send(3, 2, 64'h7766);
    tick();
    idle_in();
    byte_ready_i = 1'b1;
    b = 0;
    while (rx_q.size() < 2 && b < 20) begin
      tick();
      b++;
    end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("abort valid", byte_valid_o, 0);
    check("abort last", byte_last_o, 0);
    check("abort data", byte_data_o, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("flush valid%0d", k), byte_valid_o, 0);
    end
    check("abort bytes", rx_q.size(), 2);
    rx_q.delete();
    send(1, 2, 64'hBEEF);
    model(1, 2, 64'hBEEF);
    tick();
    idle_in();
    check("lat N valid", byte_valid_o, 0);
    tick();
    check("lat N+1 valid", byte_valid_o, 1);
    check("lat N+1 data", byte_data_o, 8'h22);
    check_stream("post", 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
